// File: rtl/ws2812b_pkg.sv
// rtl/ws2812b_pkg.sv - shared WS2812B line encoding, states and error codes
package ws2812b_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    IDLE = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } ws_state_t;

  localparam logic [1:0] ERR_GLITCH  = 2'b01;
  localparam logic [1:0] ERR_STUCK   = 2'b10;
  localparam logic [1:0] ERR_PARTIAL = 2'b11;

  localparam int BITS_PER_LED = 24;

endpackage

// File: rtl/ws2812b_sync.sv
// rtl/ws2812b_sync.sv - multi-flop input synchronizer with registered edge strobes
module ws2812b_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sff;

  // Shift the pin through the chain; strobes line up with the first cycle of the new dout level
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sff  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sff  <= {sff[SYNC_STAGES-2:0], din};
      rise <= sff[SYNC_STAGES-2] & ~sff[SYNC_STAGES-1];
      fall <= ~sff[SYNC_STAGES-2] & sff[SYNC_STAGES-1];
    end
  end

  assign dout = sff[SYNC_STAGES-1];

endmodule

// File: rtl/ws2812b_in_module.sv
// rtl/ws2812b_in_module.sv - WS2812B NRZ pulse-width decoder producing 24-bit LED words
module ws2812b_in_module
  import ws2812b_pkg::*;
#(
  parameter int CYCLES_MIN       = 2,
  parameter int CYCLES_THRESHOLD = 4,
  parameter int CYCLES_MAX       = 7,
  parameter int CYCLES_RET       = 40,
  parameter int CYCLES_CNT_WIDTH = 6,
  parameter int SYNC_STAGES      = 2,
  parameter int LEDCOUNT_WIDTH   = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      ws2812b_data,
  output logic [BITS_PER_LED-1:0]   bitstream,
  output logic                      bitstream_valid,
  output logic                      frame_end,
  output logic [LEDCOUNT_WIDTH-1:0] frame_led_count,
  output logic                      error,
  output logic [1:0]                error_code,
  output logic                      synced,
  output logic [3:0]                debug_info
);

  localparam int CW = CYCLES_CNT_WIDTH;
  localparam logic [CW-1:0] CNT_MIN    = CW'(CYCLES_MIN);
  localparam logic [CW-1:0] CNT_THR    = CW'(CYCLES_THRESHOLD);
  localparam logic [CW-1:0] CNT_MAX_M1 = CW'(CYCLES_MAX - 1);
  localparam logic [CW-1:0] CNT_RET_M1 = CW'(CYCLES_RET - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [4:0]    LAST_BIT   = 5'(BITS_PER_LED - 1);

  logic s, s_rise, s_fall;

  ws2812b_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .din    (ws2812b_data),
    .dout   (s),
    .rise   (s_rise),
    .fall   (s_fall)
  );

  ws_state_t                 state, state_nxt;
  logic [CW-1:0]             cnt, cnt_nxt, cnt_inc;
  logic [4:0]                bit_count, bit_count_nxt;
  logic [BITS_PER_LED-2:0]   shreg, shreg_nxt;
  logic [BITS_PER_LED-1:0]   shifted, bitstream_nxt;
  logic [LEDCOUNT_WIDTH-1:0] led_count, led_count_nxt, led_inc, frame_led_count_nxt;
  logic                      valid_nxt, frame_end_nxt, error_nxt;
  logic [1:0]                error_code_nxt;

  assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_ONE;
  assign led_inc = (led_count == '1) ? led_count : led_count + 1'b1;
  assign shifted = {shreg, (cnt >= CNT_THR)};

  // Register state and all datapath values computed by the next-state logic
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= HUNT;
      cnt             <= '0;
      bit_count       <= '0;
      shreg           <= '0;
      led_count       <= '0;
      bitstream       <= '0;
      bitstream_valid <= 1'b0;
      frame_end       <= 1'b0;
      frame_led_count <= '0;
      error           <= 1'b0;
      error_code      <= 2'b00;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      bit_count       <= bit_count_nxt;
      shreg           <= shreg_nxt;
      led_count       <= led_count_nxt;
      bitstream       <= bitstream_nxt;
      bitstream_valid <= valid_nxt;
      frame_end       <= frame_end_nxt;
      frame_led_count <= frame_led_count_nxt;
      error           <= error_nxt;
      error_code      <= error_code_nxt;
    end
  end

  // Pulse-width decoding: measure high and low phases, classify bits, words, gaps and errors
  always_comb begin
    state_nxt           = state;
    cnt_nxt             = cnt;
    bit_count_nxt       = bit_count;
    shreg_nxt           = shreg;
    led_count_nxt       = led_count;
    bitstream_nxt       = bitstream;
    valid_nxt           = 1'b0;
    frame_end_nxt       = 1'b0;
    frame_led_count_nxt = frame_led_count;
    error_nxt           = 1'b0;
    error_code_nxt      = error_code;
    case (state)
      HUNT: begin
        if (s) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_RET_M1) begin
          state_nxt     = IDLE;
          cnt_nxt       = '0;
          bit_count_nxt = '0;
          shreg_nxt     = '0;
          led_count_nxt = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      IDLE: begin
        if (s_rise) begin
          state_nxt = HIGH;
          cnt_nxt   = CNT_ONE;
        end
      end
      HIGH: begin
        if (s_fall) begin
          if (cnt < CNT_MIN) begin
            // Too short to be a real bit: drop the word and resynchronise on a gap
            error_nxt      = 1'b1;
            error_code_nxt = ERR_GLITCH;
            state_nxt      = HUNT;
            cnt_nxt        = '0;
            bit_count_nxt  = '0;
            shreg_nxt      = '0;
          end else begin
            shreg_nxt = shifted[BITS_PER_LED-2:0];
            state_nxt = LOW;
            cnt_nxt   = CNT_ONE;
            if (bit_count == LAST_BIT) begin
              bitstream_nxt = shifted;
              valid_nxt     = 1'b1;
              bit_count_nxt = '0;
              led_count_nxt = led_inc;
            end else begin
              bit_count_nxt = bit_count + 5'd1;
            end
          end
        end else if (cnt >= CNT_MAX_M1) begin
          error_nxt      = 1'b1;
          error_code_nxt = ERR_STUCK;
          state_nxt      = HUNT;
          cnt_nxt        = '0;
          bit_count_nxt  = '0;
          shreg_nxt      = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      LOW: begin
        if (s_rise) begin
          state_nxt = HIGH;
          cnt_nxt   = CNT_ONE;
        end else if (cnt >= CNT_RET_M1) begin
          frame_end_nxt       = 1'b1;
          frame_led_count_nxt = led_count;
          led_count_nxt       = '0;
          state_nxt           = IDLE;
          cnt_nxt             = '0;
          if (bit_count != 5'd0) begin
            error_nxt      = 1'b1;
            error_code_nxt = ERR_PARTIAL;
            bit_count_nxt  = '0;
            shreg_nxt      = '0;
          end
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  assign synced     = (state != HUNT);
  assign debug_info = {state, bit_count[1:0]};

endmodule

// File: tb/tb_ws2812b_in_module.sv
// tb/tb_ws2812b_in_module.sv - scoreboard bench for the WS2812B decoder
module tb_ws2812b_in_module;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        ws2812b_data = 1'b0;
  logic [23:0] bitstream;
  logic        bitstream_valid;
  logic        frame_end;
  logic [7:0]  frame_led_count;
  logic        error;
  logic [1:0]  error_code;
  logic        synced;
  logic [3:0]  debug_info;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int leds;
    bit err;
  } frame_t;

  logic [23:0] wq[$];
  frame_t      fq[$];
  logic [1:0]  eq[$];

  logic [23:0] wexp;
  frame_t      fexp;
  logic [1:0]  eexp;

  ws2812b_in_module dut (
    .clk             (clk),
    .resetn          (resetn),
    .ws2812b_data    (ws2812b_data),
    .bitstream       (bitstream),
    .bitstream_valid (bitstream_valid),
    .frame_end       (frame_end),
    .frame_led_count (frame_led_count),
    .error           (error),
    .error_code      (error_code),
    .synced          (synced),
    .debug_info      (debug_info)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic line_low(input int n);
    ws2812b_data = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input bit b);
    ws2812b_data = 1'b1;
    repeat (b ? 5 : 3) @(negedge clk);
    ws2812b_data = 1'b0;
    repeat (b ? 3 : 5) @(negedge clk);
  endtask

  task automatic send_bits(input logic [23:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[23-i]);
  endtask

  task automatic send_word(input logic [23:0] w);
    wq.push_back(w);
    send_bits(w, 24);
  endtask

  // Scoreboard: pop the expectation matching each DUT output pulse
  always @(negedge clk) begin
    if (resetn) begin
      if (bitstream_valid) begin
        if (wq.size() == 0) check("valid_unexpected", 32'(bitstream_valid), 32'd0);
        else begin
          wexp = wq.pop_front();
          check("word", 32'(bitstream), 32'(wexp));
        end
      end
      if (frame_end) begin
        if (fq.size() == 0) check("frame_unexpected", 32'(frame_end), 32'd0);
        else begin
          fexp = fq.pop_front();
          check("frame_leds", 32'(frame_led_count), 32'(fexp.leds));
          check("frame_err_same_cycle", 32'(error), 32'(fexp.err));
        end
      end
      if (error) begin
        if (eq.size() == 0) check("error_unexpected", 32'(error_code), 32'd0);
        else begin
          eexp = eq.pop_front();
          check("error_code", 32'(error_code), 32'(eexp));
        end
      end
    end
  end

  initial begin
    logic [23:0] w;
    #3 resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_bitstream", 32'(bitstream), 32'd0);
    check("rst_valid", 32'(bitstream_valid), 32'd0);
    check("rst_synced", 32'(synced), 32'd0);
    check("rst_flc", 32'(frame_led_count), 32'd0);
    check("rst_debug", 32'(debug_info), 32'd0);
    resetn = 1'b1;

    line_low(50);
    check("synced_after_gap", 32'(synced), 32'd1);

    send_word(24'hA5C30F);
    fq.push_back('{leds: 1, err: 1'b0});
    line_low(60);
    check("bitstream_held", 32'(bitstream), 32'hA5C30F);

    for (int i = 0; i < 36; i++) begin
      w = 24'($urandom);
      send_word(w);
    end
    fq.push_back('{leds: 36, err: 1'b0});
    line_low(60);

    send_bits(24'h5A5A5A, 5);
    eq.push_back(2'b01);
    ws2812b_data = 1'b1;
    @(negedge clk);
    line_low(5);
    check("synced_after_glitch", 32'(synced), 32'd0);
    send_bits(24'hFFFFFF, 24);
    line_low(60);
    send_word(24'h123456);
    fq.push_back('{leds: 1, err: 1'b0});
    line_low(60);

    eq.push_back(2'b10);
    ws2812b_data = 1'b1;
    repeat (10) @(negedge clk);
    line_low(3);
    check("synced_after_stuck", 32'(synced), 32'd0);
    line_low(60);

    send_bits(24'hABCDEF, 10);
    eq.push_back(2'b11);
    fq.push_back('{leds: 0, err: 1'b1});
    line_low(60);
    check("bitstream_after_partial", 32'(bitstream), 32'h123456);

    send_bits(24'h0F0F0F, 11);
    ws2812b_data = 1'b1;
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("midreset_bitstream", 32'(bitstream), 32'd0);
    check("midreset_error_code", 32'(error_code), 32'd0);
    check("midreset_synced", 32'(synced), 32'd0);
    check("midreset_valid", 32'(bitstream_valid), 32'd0);
    resetn = 1'b1;
    ws2812b_data = 1'b0;
    send_bits(24'hC3C3C3, 24);
    line_low(60);
    send_word(24'h00FF81);
    fq.push_back('{leds: 1, err: 1'b0});
    line_low(60);

    check("words_left", 32'(wq.size()), 32'd0);
    check("frames_left", 32'(fq.size()), 32'd0);
    check("errors_left", 32'(eq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ws2812b_in_module.md
Name: ws2812b_in_module

Overview:
- Receive-side counterpart of ws2812b_out_module: decodes a single-wire WS2812B NRZ pulse-width stream into 24-bit per-LED words.
- Used as loopback checker for the LED driver chain (pmod1_1 wired back to an input pin) and as a front end for daisy-chain / sniffer designs.
- Runs on the same 9 MHz PLL clock as the transmitter.
- Reports words, frame ends (latch gaps), per-frame LED counts and line errors.

Parameters:
- CYCLES_MIN, 2: high pulses shorter than this are glitches.
- CYCLES_THRESHOLD, 4: high width >= this decodes as 1, otherwise 0. Midpoint of the 3/5-cycle transmitter encoding.
- CYCLES_MAX, 7: high held for this many cycles is a stuck-high error.
- CYCLES_RET, 40: low held for this many cycles is a latch/frame end.
- CYCLES_CNT_WIDTH, 6: width of the pulse counter. Must hold CYCLES_RET.
- SYNC_STAGES, 2: input synchronizer depth, 2 or more.
- LEDCOUNT_WIDTH, 8: width of the LED counters.

Ports:
- clk  in  1  system clock (9 MHz PLL global)
- resetn  in  1  asynchronous active-low reset
- ws2812b_data  in  1  asynchronous serial line
- bitstream  out  24  last decoded word, MSB first as received ({G,R,B}); held until the next word
- bitstream_valid  out  1  one-cycle pulse: bitstream updated
- frame_end  out  1  one-cycle pulse: latch gap detected
- frame_led_count  out  LEDCOUNT_WIDTH  number of complete words in the frame just ended; valid from the frame_end pulse onward
- error  out  1  one-cycle pulse on a line error
- error_code  out  2  01 glitch, 10 stuck-high, 11 partial word at latch; held until the next error
- synced  out  1  high while not in HUNT
- debug_info  out  4  {state[1:0], bit_count[1:0]}

Behaviour:
- Reset (async, resetn=0):
  - state=HUNT.
  - Counters, bitstream and shift register are 0.
  - All pulses, error_code, frame_led_count and synced are 0.
  - Synchronizer flops are cleared to 0.
- Input: s = ws2812b_data after SYNC_STAGES flops. All decisions use s; edges are detected against the previous s.
- cnt saturates at its maximum and never wraps.
- bit_count is 0..23. led_count saturates at 2^LEDCOUNT_WIDTH-1.
- States:
  - HUNT: cnt counts cycles with s=0 and clears on s=1. When cnt reaches CYCLES_RET-1 with s=0: go to IDLE and clear bit_count and led_count. No frame_end is issued from HUNT.
  - IDLE: on s=1, go to HIGH with cnt=1.
  - HIGH:
    - While s=1, cnt increments. If cnt reaches CYCLES_MAX: error, code 10, go to HUNT, discard the partial word.
    - On s=0 with cnt<CYCLES_MIN: error, code 01, go to HUNT, discard the partial word.
    - On s=0 otherwise: shift in bit (cnt>=CYCLES_THRESHOLD) at the LSB, increment bit_count, go to LOW with cnt=1.
    - If this was the 24th bit: bitstream <= shifted word, bitstream_valid=1 the next cycle, bit_count=0, led_count++.
  - LOW:
    - On s=1: go to HIGH with cnt=1. Low-phase width is otherwise unchecked.
    - If s=0 until cnt reaches CYCLES_RET: frame_end=1, frame_led_count<=led_count, led_count=0, go to IDLE.
    - If bit_count!=0 at that point: also error with code 11, partial bits dropped, bit_count=0.
- Latency:
  - bitstream_valid asserts SYNC_STAGES+1 clk cycles after the falling pin edge of bit 23.
  - frame_end asserts SYNC_STAGES+CYCLES_RET cycles after the last falling pin edge.
- Simultaneous events:
  - A word completing and an error cannot coincide.
  - frame_end and error(11) coincide in the same cycle by design.
- No backpressure: the consumer must accept each bitstream_valid pulse. The minimum word spacing is 24 bit periods.
- Reset mid-word: everything is cleared and the block returns to HUNT. A full latch gap is required before decoding resumes.

Decomposition:
- Package ws2812b_pkg holds:
  - state encoding (HUNT=0, IDLE=1, HIGH=2, LOW=3);
  - error codes ERR_GLITCH=2'b01, ERR_STUCK=2'b10, ERR_PARTIAL=2'b11;
  - BITS_PER_LED=24.
  The package is shared with ws2812b_out_module.
- Sub-module ws2812b_sync: parameterised SYNC_STAGES synchronizer with registered rise/fall strobes. Async clear on resetn.

Test Plan:
- Reset release, line low 40+ cycles, then 24 bits of 0xA5C30F (high 3 = 0, high 5 = 1, 8-cycle period), then low 60 cycles:
  - synced=1 after the gap;
  - one bitstream_valid with bitstream=24'hA5C30F;
  - frame_end pulse with frame_led_count=1;
  - no error.
- Loopback with ws2812b_out_module, 36 LEDs (red/green/blue init patterns), 90000-cycle fps gap:
  - 36 valid pulses, word 0 = {7'b0,g0,7'b0,r0,7'b0,b0};
  - frame_end with frame_led_count=36.
- 1-cycle high glitch mid-word: error with error_code=01, synced=0. The next word is decoded only after a 40-cycle gap.
- Line held high 10 cycles: error with code 10 at cnt=7, then HUNT.
- 10 bits followed by a 40-cycle low: frame_end and error (code 11) in the same cycle, frame_led_count=0, bitstream unchanged.
- resetn asserted while the 12th bit is high: all outputs 0 within the reset, no valid. After release, decoding waits for a full gap.
